// File: rtl/johnson_counter_gen.sv
// ---------------------------------------------------------------------------
// johnson_counter_gen
//
// Parametrised phase/sequence generator. Runs either as a Johnson
// (twisted-ring) counter with 2*WIDTH states, or as a one-hot ring counter
// with WIDTH states. Supports count enable, direction, parallel load with a
// legality check, a registered phase index, a wrap pulse and self-correction
// of illegal states.
//
// Parameters:
//   WIDTH    register width, >= 2
//   MODE     0 = Johnson, 1 = one-hot ring
//   PW       phase width, derived from WIDTH (leave at default)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   en       count enable, one step per cycle
//   dir      0 = up (shift toward MSB), 1 = down (shift toward LSB)
//   load     parallel load request (wins over en)
//   load_val value written on load
//   q_out    counter state
//   phase    index of q_out in the count sequence, 0 = reset state
//   tc       one-cycle pulse after a count step that wrapped the sequence
//   err      one-cycle pulse after an illegal state was loaded or detected
// ---------------------------------------------------------------------------
module johnson_counter_gen #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic [PW-1:0]    phase,
  output logic             tc,
  output logic             err
);

  // Number of states in the sequence and the index of the last one.
  localparam int NumStates = (MODE == 1) ? WIDTH : 2*WIDTH;
  localparam logic [PW-1:0] LastPhase = PW'(NumStates - 1);

  // Reset code: all zeros for Johnson, a single one in bit 0 for ring.
  localparam logic [WIDTH-1:0] ResetCode = (MODE == 1) ? WIDTH'(1) : '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  // Number of ones in a code word.
  function automatic int popCount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  // A Johnson code is a single block of ones anchored at one end, so it
  // has at most one 0/1 boundary between adjacent bits. That gives exactly
  // 2 + 2*(WIDTH-1) = 2*WIDTH legal codes. A ring code has one bit set.
  function automatic logic isLegal(input logic [WIDTH-1:0] v);
    int edges;
    logic ok;
    edges = 0;
    if (MODE == 1) begin
      ok = (popCount(v) == 1);
    end else begin
      for (int i = 0; i < WIDTH-1; i++) begin
        if (v[i] != v[i+1]) begin
          edges = edges + 1;
        end
      end
      ok = (edges <= 1);
    end
    return ok;
  endfunction

  // Position of a legal code in the sequence. Johnson codes filling from
  // the LSB sit in the first half; codes emptying from the LSB sit in the
  // second half, counted back from 2*WIDTH.
  function automatic logic [PW-1:0] phaseOf(input logic [WIDTH-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    if (MODE == 1) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          idx = PW'(i);
        end
      end
    end else if (v[0] || (v == '0)) begin
      idx = PW'(popCount(v));
    end else begin
      idx = PW'(2*WIDTH - popCount(v));
    end
    return idx;
  endfunction

  // One shift step. Johnson inverts the bit fed back around the ring.
  function automatic logic [WIDTH-1:0] stepCode(input logic [WIDTH-1:0] v,
                                                input logic down);
    logic [WIDTH-1:0] nxt;
    if (MODE == 1) begin
      nxt = down ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    end else begin
      nxt = down ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
    end
    return nxt;
  endfunction

  // Next-state logic. Load wins over counting. The phase follows the
  // count arithmetically, so wrap detection is a compare on the phase.
  // Any illegal state (bad load value or an upset register) is replaced
  // by the reset code with an err pulse.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (isLegal(load_val)) begin
        count_d = load_val;
        phase_d = phaseOf(load_val);
      end else begin
        count_d = ResetCode;
        phase_d = '0;
        err_d   = 1'b1;
      end
    end else if (en) begin
      if (!isLegal(count_q)) begin
        count_d = ResetCode;
        phase_d = '0;
        err_d   = 1'b1;
      end else if (!dir) begin
        count_d = stepCode(count_q, 1'b0);
        if (phase_q == LastPhase) begin
          phase_d = '0;
          tc_d    = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end else begin
        count_d = stepCode(count_q, 1'b1);
        if (phase_q == '0) begin
          phase_d = LastPhase;
          tc_d    = 1'b1;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ResetCode;
      phase_q <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign q_out = count_q;
  assign phase = phase_q;
  assign tc    = tc_q;
  assign err   = err_q;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// ---------------------------------------------------------------------------
// tb_johnson_counter_gen
//
// Drives three counters from shared controls: a 4-bit Johnson, a 4-bit
// ring and a 5-bit Johnson. A reference model tracks each counter as a
// phase number and derives the expected code from that phase.
// ---------------------------------------------------------------------------
module tb_johnson_counter_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, dir, load;
  logic [3:0] lv4;
  logic [4:0] lv5;

  logic [3:0] qA, qB;
  logic [4:0] qC;
  logic [2:0] pA, pB;
  logic [3:0] pC;
  logic       tcA, tcB, tcC, errA, errB, errC;

  johnson_counter_gen #(.WIDTH(4), .MODE(0)) dA (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4),
    .q_out(qA), .phase(pA), .tc(tcA), .err(errA));

  johnson_counter_gen #(.WIDTH(4), .MODE(1)) dB (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4),
    .q_out(qB), .phase(pB), .tc(tcB), .err(errB));

  johnson_counter_gen #(.WIDTH(5), .MODE(0)) dC (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv5),
    .q_out(qC), .phase(pC), .tc(tcC), .err(errC));

  int    wid [3] = '{4, 4, 5};
  int    md  [3] = '{0, 1, 0};
  int    mPhase [3];
  bit    mTc [3];
  bit    mErr [3];
  bit    mUpset [3];
  int    compared = 0;
  int    mismatched = 0;
  string stepName = "init";

  // Sequence length of counter k.
  function automatic int seqLen(int k);
    return (md[k] == 1) ? wid[k] : 2*wid[k];
  endfunction

  // The code that sits at position p of counter k's sequence.
  function automatic logic [7:0] codeOf(int k, int p);
    int w;
    w = wid[k];
    if (md[k] == 1) return 8'(1 << p);
    if (p <= w) return 8'((1 << p) - 1);
    return 8'(((1 << w) - 1) & ~((1 << (p - w)) - 1));
  endfunction

  // Position of a value in the sequence, or -1 if it never appears.
  function automatic int seqIndex(int k, logic [7:0] v);
    for (int p = 0; p < seqLen(k); p++) begin
      if (codeOf(k, p) == v) return p;
    end
    return -1;
  endfunction

  // Advance counter k's model by one clock edge.
  task automatic modelTick(int k, logic [7:0] lv);
    int n, idx;
    n = seqLen(k);
    if (rst) begin
      mPhase[k] = 0; mTc[k] = 0; mErr[k] = 0; mUpset[k] = 0;
    end else if (load) begin
      idx = seqIndex(k, lv);
      mTc[k] = 0; mUpset[k] = 0;
      if (idx < 0) begin
        mPhase[k] = 0; mErr[k] = 1;
      end else begin
        mPhase[k] = idx; mErr[k] = 0;
      end
    end else if (en) begin
      if (mUpset[k]) begin
        mPhase[k] = 0; mErr[k] = 1; mTc[k] = 0; mUpset[k] = 0;
      end else begin
        mErr[k] = 0;
        if (!dir) begin
          mTc[k] = (mPhase[k] == n - 1);
          mPhase[k] = (mPhase[k] + 1) % n;
        end else begin
          mTc[k] = (mPhase[k] == 0);
          mPhase[k] = (mPhase[k] + n - 1) % n;
        end
      end
    end else begin
      mTc[k] = 0; mErr[k] = 0;
    end
  endtask

  task automatic checkOne(string tag, logic [7:0] obs, logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", stepName, tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] oq [3];
    logic [7:0] op [3];
    logic       ot [3];
    logic       oe [3];
    oq[0] = {4'd0, qA}; oq[1] = {4'd0, qB}; oq[2] = {3'd0, qC};
    op[0] = {5'd0, pA}; op[1] = {5'd0, pB}; op[2] = {4'd0, pC};
    ot[0] = tcA;  ot[1] = tcB;  ot[2] = tcC;
    oe[0] = errA; oe[1] = errB; oe[2] = errC;
    for (int k = 0; k < 3; k++) begin
      if (!mUpset[k]) begin
        checkOne($sformatf("q%0d", k), oq[k], codeOf(k, mPhase[k]));
        checkOne($sformatf("phase%0d", k), op[k], 8'(mPhase[k]));
      end
      checkOne($sformatf("tc%0d", k), {7'd0, ot[k]}, {7'd0, mTc[k]});
      checkOne($sformatf("err%0d", k), {7'd0, oe[k]}, {7'd0, mErr[k]});
    end
  endtask

  // Drive one cycle of inputs at the falling edge, optionally corrupt the
  // 5-bit counter's register, then update the models at the rising edge
  // and check shortly after it.
  task automatic applyStimulus(bit r, bit e, bit d, bit l,
                               logic [3:0] v4, logic [4:0] v5, bit upsetC);
    @(negedge clk);
    rst = r; en = e; dir = d; load = l; lv4 = v4; lv5 = v5;
    if (upsetC) begin
      force dC.count_q = 5'b10101;
      #1 release dC.count_q;
      mUpset[2] = 1;
    end
    @(posedge clk);
    modelTick(0, {4'd0, lv4});
    modelTick(1, {4'd0, lv4});
    modelTick(2, {3'd0, lv5});
    #1;
    checkOutput();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1; en = 0; dir = 0; load = 0; lv4 = '0; lv5 = '0;
    for (int k = 0; k < 3; k++) begin
      mPhase[k] = 0; mTc[k] = 0; mErr[k] = 0; mUpset[k] = 0;
    end

    stepName = "reset";
    repeat (2) applyStimulus(1, 0, 0, 0, 4'h0, 5'h00, 0);

    stepName = "up8";
    repeat (8) applyStimulus(0, 1, 0, 0, 4'h0, 5'h00, 0);

    stepName = "down2";
    repeat (2) applyStimulus(0, 1, 1, 0, 4'h0, 5'h00, 0);

    stepName = "hold";
    repeat (3) applyStimulus(0, 0, 1, 0, 4'h0, 5'h00, 0);

    stepName = "loadLegal";
    applyStimulus(0, 1, 0, 1, 4'b0111, 5'b00111, 0);
    stepName = "loadIllegal";
    applyStimulus(0, 1, 0, 1, 4'b0101, 5'b01010, 0);
    stepName = "afterLoad";
    applyStimulus(0, 0, 0, 0, 4'b0000, 5'b00000, 0);

    stepName = "ringUp";
    applyStimulus(1, 0, 0, 0, 4'h0, 5'h00, 0);
    repeat (4) applyStimulus(0, 1, 0, 0, 4'h0, 5'h00, 0);
    stepName = "ringDown";
    applyStimulus(0, 1, 1, 0, 4'h0, 5'h00, 0);
    stepName = "ringLoadBad";
    applyStimulus(0, 0, 0, 1, 4'b0011, 5'b11000, 0);

    stepName = "upset";
    applyStimulus(1, 0, 0, 0, 4'h0, 5'h00, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 4'h0, 5'h00, 0);
    applyStimulus(0, 0, 0, 0, 4'h0, 5'h00, 1);
    stepName = "upsetFix";
    applyStimulus(0, 1, 0, 0, 4'h0, 5'h00, 0);
    stepName = "rstOverride";
    applyStimulus(0, 1, 0, 0, 4'h0, 5'h00, 0);
    applyStimulus(1, 1, 0, 1, 4'b0011, 5'b00011, 0);

    stepName = "random";
    for (int i = 0; i < 500; i++) begin
      bit r, e, d, l;
      logic [3:0] v4;
      logic [4:0] v5;
      r = ($urandom_range(0, 99) < 3);
      l = ($urandom_range(0, 99) < 15);
      e = ($urandom_range(0, 99) < 75);
      d = (i % 40 < 20) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        v4 = 4'(codeOf($urandom_range(0, 1), $urandom_range(0, 3)));
        v5 = 5'(codeOf(2, $urandom_range(0, 9)));
      end else begin
        v4 = 4'($urandom);
        v5 = 5'($urandom);
      end
      applyStimulus(r, e, d, l, v4, v5, (i % 97 == 50) && !r && !l && !e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/johnson_counter_gen.md
Name: johnson_counter_gen

Overview:
- Parametrised successor to the fixed 4-bit Johnson counter.
- Width is configurable, and the block runs as either a Johnson (twisted-ring) counter or a one-hot ring counter.
- Adds enable, up/down direction, parallel load with legality check, a registered phase index, a wrap pulse and illegal-state self-correction.
- Used as a phase/sequence generator for multi-phase timing and control logic.

Parameters:
- WIDTH, 4, register width; legal range >= 2.
- MODE, 0, 0 = Johnson (2*WIDTH states), 1 = one-hot ring (WIDTH states).
- PW, $clog2(2*WIDTH), phase output width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per cycle when high.
- dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
- load  input  1  parallel load request.
- load_val  input  WIDTH  value written on load.
- q_out  output  WIDTH  counter state.
- phase  output  PW  index of q_out in the count sequence (0 = reset state).
- tc  output  1  one-cycle pulse; the last step wrapped the sequence.
- err  output  1  one-cycle pulse; an illegal state was loaded or detected and replaced.

Behaviour:
- Reset values (rst=1 at a rising edge):
  - q_out = 0 (MODE 0) or 1 (MODE 1, i.e. {0..0,1}).
  - phase = 0, tc = 0, err = 0.
- Priority per edge: rst > load > en. With none active, all state holds; tc and err return to 0.
- Johnson step rules:
  - up: q <= {q[W-2:0], ~q[W-1]}
  - down: q <= {~q[0], q[W-1:1]}
- Ring step rules:
  - up: q <= {q[W-2:0], q[W-1]}
  - down: q <= {q[0], q[W-1:1]}
- Legal codes:
  - Johnson: the 2W codes reachable from 0.
  - Ring: exactly one bit set.
- Phase mapping:
  - Johnson: if q[0]=1 or q=0, phase = popcount(q); else phase = 2W - popcount(q).
  - Ring: phase = index of the set bit.
  - phase is registered and always consistent with q_out in the same cycle (zero latency relative to q_out).
- tc: set to 1 for exactly one cycle after a count step that wraps.
  - up wrap: from phase LAST to 0.
  - down wrap: from phase 0 to LAST.
  - LAST = 2W-1 (Johnson) or W-1 (ring).
  - Loads never raise tc.
- Load:
  - Legal load_val: q_out <= load_val and phase updated, next cycle.
  - Illegal load_val: q_out <= reset value, phase <= 0, err=1 for one cycle.
  - load with en=1 performs the load only; no count step.
- Self-correction: if a count step sees an illegal current q_out (e.g. upset), q_out <= reset value, phase <= 0, err=1, tc=0.
- dir is sampled on each step; changing it mid-sequence reverses from the current state with no idle cycle.
- rst mid-operation overrides pending load/en; the counter restarts from the reset value on the next enabled step.

Test Plan:
1. WIDTH=4, MODE=0, rst=1 for 2 cycles -> q_out=0000, phase=0, tc=0, err=0.
2. en=1, dir=0, 8 cycles -> q_out 0001,0011,0111,1111,1110,1100,1000,0000; phase 1..7,0; tc=1 only with the final 0000.
3. From 0000, en=1, dir=1 -> q_out=1000, phase=7, tc=1; next step 1100, phase=6, tc=0. Then en=0 for 3 cycles -> q_out holds 1100.
4. Simultaneous load=1, en=1, load_val=0111 -> q_out=0111, phase=3, tc=0, err=0. Then load_val=0101 -> q_out=0000, phase=0, err=1 for one cycle.
5. WIDTH=4, MODE=1, rst -> 0001. Up steps -> 0010,0100,1000,0001 with tc on 0001. Down from 0001 -> 1000, phase=3, tc=1. load_val=0011 -> q_out=0001, err=1.
6. WIDTH=5, MODE=0: force q_out=10101 then en=1 -> q_out=00000, err=1. Also rst=1 asserted together with load=1, en=1 -> q_out=00000, no err, no tc.
